// File: rtl/fma_wb_responder.sv
// fma_wb_responder
// Wishbone classic single-beat responder wrapped around a two-stage unsigned
// multiply-add datapath (o = a*b + c, 16-bit wrap). Operand writes issue jobs,
// results are buffered in a FIFO that the management SoC drains via reads.
// Issue is credit-gated so that results in the FIFO plus jobs in flight never
// exceed FIFO_DEPTH, which makes FIFO overflow impossible.
module fma_wb_responder #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] ADDR_BASE  = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        REG_OPND   = 2'd0,
        REG_RESULT = 2'd1,
        REG_STATUS = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;

    // Byte selects and the byte-offset address bits carry no meaning here.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{wbs_sel_i, wbs_adr_i[1:0]};

    // Bus decode
    reg_sel_e          sel;
    logic              hit;
    logic              req;
    logic              opnd_wr_req;
    logic              credit_ok;
    logic              accept;
    logic              issue;
    logic              pop_req;
    logic              do_pop;
    logic              status_wr;
    logic              flush;

    // FIFO state
    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic [CNT_W:0]    occupancy;

    // Datapath state
    logic              s1_v;
    logic [15:0]       s1_p;
    logic [15:0]       s1_c;
    logic [15:0]       sum;
    logic              push;

    logic              ien;
    logic [31:0]       rdata;

    assign sel         = reg_sel_e'(wbs_adr_i[3:2]);
    assign hit         = (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
    assign req         = wbs_stb_i & wbs_cyc_i & hit & ~wbs_ack_o;
    assign opnd_wr_req = req & wbs_we_i & (sel == REG_OPND);

    // Occupancy counts jobs still in the pipeline so a stalled issue waits for a
    // pop that has already retired, not merely been requested.
    assign occupancy   = {1'b0, count} + {{CNT_W{1'b0}}, s1_v};
    assign credit_ok   = (occupancy < DEPTH_OCC);
    assign accept      = req & ~(opnd_wr_req & ~credit_ok);

    assign issue       = accept & wbs_we_i & (sel == REG_OPND);
    assign pop_req     = accept & ~wbs_we_i & (sel == REG_RESULT);
    assign do_pop      = pop_req & ~empty;
    assign status_wr   = accept & wbs_we_i & (sel == REG_STATUS);
    assign flush       = status_wr & wbs_dat_i[0];

    assign empty       = (count == '0);
    assign full        = (count == DEPTH_CNT);

    // Second stage is the adder feeding the FIFO write port; a flush in the same
    // cycle discards the landing result.
    assign sum         = s1_p + s1_c;
    assign push        = s1_v & ~flush;

    // Read-data selection for the register addressed by the current request
    always_comb begin
        rdata = '0;
        case (sel)
            REG_RESULT: begin
                if (!empty) begin
                    rdata = {1'b1, 15'b0, fifo_mem[rd_ptr]};
                end
            end
            REG_STATUS: begin
                rdata[CNT_W-1:0] = count;
                rdata[8]         = empty;
                rdata[9]         = full;
                rdata[10]        = s1_v;
                rdata[16]        = ien;
            end
            default: rdata = '0;
        endcase
    end

    // Registered bus response: one-cycle ack, data only during reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= accept;
            wbs_dat_o <= (accept && !wbs_we_i) ? rdata : '0;
        end
    end

    // First pipeline stage: capture product and addend of an issued job
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s1_p <= '0;
            s1_c <= '0;
        end else begin
            s1_v <= issue;
            if (issue) begin
                s1_p <= wbs_dat_i[7:0] * wbs_dat_i[15:8];
                s1_c <= wbs_dat_i[31:16];
            end
        end
    end

    // Result storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sum;
        end
    end

    // FIFO pointers and occupancy; flush wins over any push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Interrupt enable and level interrupt, one cycle behind the FIFO count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ien <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (status_wr) begin
                ien <= wbs_dat_i[1];
            end
            irq <= ien & ~empty;
        end
    end

endmodule

// File: tb/tb_fma_wb_responder.sv
// tb_fma_wb_responder
// Scoreboard bench: bus tasks push expected read data when a transaction is
// issued, an independent monitor pops and compares on every ack. Expected data
// comes from a queue-based model of the result FIFO and the IEN bit.
module tb_fma_wb_responder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam logic [31:0] A_OPND = BASE + 32'h0;
    localparam logic [31:0] A_RES  = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;
    localparam logic [31:0] A_RSV  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = '0;
    logic [31:0] wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    logic [15:0] model_q[$];
    logic        model_ien = 1'b0;

    fma_wb_responder #(
        .FIFO_DEPTH(DEPTH),
        .ADDR_BASE (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    // Monitor: every ack consumes one expectation; idle cycles must read zero
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (wbs_ack_o) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: dat_o=%08h with no transaction pending", wbs_dat_o);
                end else begin
                    logic [31:0] e;
                    string       n;
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    if (wbs_dat_o !== e) begin
                        errors++;
                        $display("FAIL %s: dat_o=%08h expected=%08h", n, wbs_dat_o, e);
                    end
                end
            end else if (wbs_dat_o !== 32'h0) begin
                errors++;
                $display("FAIL dat_idle: dat_o=%08h expected=00000000", wbs_dat_o);
            end
        end
    end

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'(model_q.size());
        if (model_q.size() == 0)     s = s + 32'h0000_0100;
        if (model_q.size() == DEPTH) s = s + 32'h0000_0200;
        if (model_ien)               s = s + 32'h0001_0000;
        return s;
    endfunction

    task automatic bus_drive(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = 4'($urandom);
    endtask

    task automatic bus_idle();
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_dat_i = $urandom;
    endtask

    // One bus transaction, started on a negedge; exp_ack=0 means the access must
    // be ignored (miss or credit stall) for the whole wait window.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic exp_ack, input logic [31:0] exp_dat, input string name);
        logic got;
        logic exp_irq;
        if (exp_ack) begin
            exp_q.push_back(exp_dat);
            name_q.push_back(name);
        end
        bus_drive(we, adr, dat);
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wbs_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        bus_idle();
        checks++;
        if (got !== exp_ack) begin
            errors++;
            $display("FAIL %s_ack: ack_seen=%0d expected=%0d", name, got, exp_ack);
            if (exp_ack) begin
                exp_q.delete();
                name_q.delete();
            end
        end
        repeat (2) @(negedge clk);
        exp_irq = model_ien && (model_q.size() != 0);
        checks++;
        if (irq !== exp_irq) begin
            errors++;
            $display("FAIL %s_irq: irq=%0d expected=%0d", name, irq, exp_irq);
        end
    endtask

    task automatic op_opnd(input logic [31:0] d);
        int a;
        int b;
        int c;
        a = int'(d[7:0]);
        b = int'(d[15:8]);
        c = int'(d[31:16]);
        if (model_q.size() >= DEPTH) begin
            xfer(1'b1, A_OPND, d, 1'b0, 32'h0, "opnd_stall");
        end else begin
            model_q.push_back(16'((a * b + c) % 65536));
            xfer(1'b1, A_OPND, d, 1'b1, 32'h0, "opnd_wr");
        end
    endtask

    task automatic op_result_rd();
        logic [31:0] e;
        if (model_q.size() == 0) e = 32'h0;
        else                     e = 32'h8000_0000 | 32'(model_q.pop_front());
        xfer(1'b0, A_RES, $urandom, 1'b1, e, "result_rd");
    endtask

    task automatic op_result_wr();
        xfer(1'b1, A_RES, $urandom, 1'b1, 32'h0, "result_wr");
    endtask

    task automatic op_status_rd();
        xfer(1'b0, A_STAT, $urandom, 1'b1, model_status(), "status_rd");
    endtask

    task automatic op_status_wr(input logic [31:0] d);
        if (d[0]) model_q.delete();
        model_ien = d[1];
        xfer(1'b1, A_STAT, d, 1'b1, 32'h0, "status_wr");
    endtask

    task automatic op_rsvd(input logic we);
        xfer(we, A_RSV, $urandom, 1'b1, 32'h0, "rsvd");
    endtask

    task automatic op_miss(input logic we);
        logic [31:0] adr;
        adr = $urandom;
        if (adr[31:4] == BASE[31:4]) adr[4] = ~adr[4];
        xfer(we, adr, $urandom, 1'b0, 32'h0, "miss");
    endtask

    initial begin
        logic [31:0] fill_data [5];
        fill_data[0] = 32'h0000_0201;
        fill_data[1] = 32'h0010_0403;
        fill_data[2] = 32'h1234_0605;
        fill_data[3] = 32'hABCD_0807;
        fill_data[4] = 32'h0001_FFFE;

        // Reset held with a live request to STATUS
        rst = 1'b1;
        bus_drive(1'b0, A_STAT, 32'h0);
        repeat (3) @(negedge clk);
        checks++;
        if (wbs_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: ack=%0d expected=0", wbs_ack_o); end
        checks++;
        if (wbs_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: dat_o=%08h expected=00000000", wbs_dat_o); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: irq=%0d expected=0", irq); end
        bus_idle();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op_status_rd();

        // Basic job and empty read
        op_opnd(32'h0005_0302);
        op_result_rd();
        op_result_rd();

        // 16-bit wrap
        op_opnd(32'hFFFF_FFFF);
        op_result_rd();

        // Fill to credit limit, stall, free one slot, retry
        for (int i = 0; i < 5; i++) op_opnd(fill_data[i]);
        op_status_rd();
        op_result_rd();
        op_opnd(fill_data[4]);
        for (int i = 0; i < 5; i++) op_result_rd();

        // Flush
        for (int i = 0; i < 4; i++) op_opnd($urandom);
        op_status_wr(32'h1);
        op_status_rd();
        op_result_rd();

        // Interrupt and address decode
        op_status_wr(32'h2);
        op_opnd(32'h0003_0707);
        op_status_rd();
        op_result_rd();
        op_miss(1'b0);
        op_miss(1'b1);
        op_result_wr();
        op_rsvd(1'b0);
        op_rsvd(1'b1);

        // Reset arriving while an ack is on the bus
        op_status_wr(32'h3);
        op_opnd(32'h0000_0101);
        bus_drive(1'b1, A_OPND, 32'h0009_0404);
        @(posedge clk);
        #1;
        checks++;
        if (wbs_ack_o !== 1'b1) begin errors++; $display("FAIL midrst_pre_ack: ack=%0d expected=1", wbs_ack_o); end
        rst = 1'b1;
        #1;
        checks++;
        if (wbs_ack_o !== 1'b0) begin errors++; $display("FAIL midrst_ack: ack=%0d expected=0", wbs_ack_o); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq: irq=%0d expected=0", irq); end
        @(negedge clk);
        bus_idle();
        model_q.delete();
        model_ien = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        op_status_rd();
        op_result_rd();

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 40)      op_opnd($urandom);
            else if (r < 68) op_result_rd();
            else if (r < 80) op_status_rd();
            else if (r < 88) begin
                logic [31:0] d;
                d = $urandom;
                d[0] = ($urandom_range(0, 5) == 0);
                op_status_wr(d);
            end
            else if (r < 92) op_result_wr();
            else if (r < 96) op_rsvd(1'($urandom));
            else             op_miss(1'($urandom));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
